wb_wport_arbiter: RTL and testbench

//  Owns the single GPR write port after the WB stage. Pipeline WB writes always win.

---
 rtl/wb_wport_arbiter.sv | 134 +++++++++++++
 tb/tb_wb_wport_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/wb_wport_arbiter.sv
// GPR write-port arbiter: WB writes win; long-latency results wait in a small FIFO
// and drain on WB gaps, with a starvation stall request and a pending-register mask.
module wb_wport_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic        async_valid,
  output logic        async_ready,
  input  logic [4:0]  async_waddr,
  input  logic [31:0] async_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_req,
  output logic [31:0] pending_mask
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned AGE_W = $clog2(STARVE_MAX + 1);

  logic [4:0]       fifo_addr [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [DEPTH-1:0] fifo_vld;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [AGE_W-1:0] age;

  logic             empty, full, wb_act, push, store, pop;
  logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [AGE_W-1:0] age_nxt;
  logic [DEPTH-1:0] fifo_vld_nxt;
  logic [31:0]      mask_raw;

  // Handshake and arbitration decisions from registered state.
  always_comb begin
    empty  = (count == '0);
    full   = (count == CNT_W'(DEPTH));
    wb_act = wb_we && (wb_waddr != 5'd0);
    push   = async_valid && !full && !rst;
    store  = push && (async_waddr != 5'd0);
    pop    = !wb_act && !empty;
  end

  // Next-state for pointers, occupancy, valid bits and starvation age.
  always_comb begin
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    count_nxt    = count;
    fifo_vld_nxt = fifo_vld;
    age_nxt      = age;
    if (pop) begin
      rd_ptr_nxt           = rd_ptr + 1'b1;
      fifo_vld_nxt[rd_ptr] = 1'b0;
    end
    if (store) begin
      wr_ptr_nxt           = wr_ptr + 1'b1;
      fifo_vld_nxt[wr_ptr] = 1'b1;
    end
    case ({store, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
    // Age only counts while the head sits blocked behind WB traffic.
    if (pop || empty)
      age_nxt = '0;
    else if (age < AGE_W'(STARVE_MAX))
      age_nxt = age + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fifo_vld <= '0;
      age      <= '0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      fifo_vld <= fifo_vld_nxt;
      age      <= age_nxt;
    end
  end

  // Payload storage needs no reset; validity is tracked by fifo_vld.
  always_ff @(posedge clk) begin
    if (store) begin
      fifo_addr[wr_ptr] <= async_waddr;
      fifo_data[wr_ptr] <= async_wdata;
    end
  end

  always_comb begin
    mask_raw = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (fifo_vld[i])
        mask_raw = mask_raw | (32'd1 << fifo_addr[i]);
    end
  end

  // Write-port mux; everything is forced quiet while reset is held.
  always_comb begin
    rf_we        = 1'b0;
    rf_waddr     = 5'd0;
    rf_wdata     = 32'd0;
    async_ready  = 1'b0;
    stall_req    = 1'b0;
    pending_mask = '0;
    if (!rst) begin
      async_ready  = !full;
      stall_req    = !empty && (age >= AGE_W'(STARVE_MAX));
      pending_mask = mask_raw;
      if (wb_act) begin
        rf_we    = 1'b1;
        rf_waddr = wb_waddr;
        rf_wdata = wb_wdata;
      end else if (!empty) begin
        rf_we    = 1'b1;
        rf_waddr = fifo_addr[rd_ptr];
        rf_wdata = fifo_data[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_wb_wport_arbiter.sv
// Bench for wb_wport_arbiter: directed scenarios plus random traffic against a
// queue-based reference model of the write-port arbitration rules.
module tb_wb_wport_arbiter;

  localparam int unsigned DEPTH      = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        async_valid;
  logic        async_ready;
  logic [4:0]  async_waddr;
  logic [31:0] async_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic [31:0] pending_mask;

  wb_wport_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .async_valid(async_valid), .async_ready(async_ready),
    .async_waddr(async_waddr), .async_wdata(async_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_req(stall_req), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  int unsigned age_m = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model.
  task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
    logic        wact, exp_ready, exp_we, exp_stall, popped;
    logic [4:0]  exp_a;
    logic [31:0] exp_d, exp_m;
    @(negedge clk);
    wb_we = we; wb_waddr = wa; wb_wdata = wd;
    async_valid = av; async_waddr = aa; async_wdata = ad;
    #1;
    wact      = we && (wa != 5'd0);
    exp_ready = (q.size() != DEPTH);
    exp_stall = (q.size() > 0) && (age_m >= STARVE_MAX);
    exp_we = 1'b0; exp_a = 5'd0; exp_d = 32'd0;
    if (wact) begin
      exp_we = 1'b1; exp_a = wa; exp_d = wd;
    end else if (q.size() > 0) begin
      exp_we = 1'b1; exp_a = q[0].a; exp_d = q[0].d;
    end
    exp_m = 32'd0;
    foreach (q[i]) exp_m[q[i].a] = 1'b1;
    check("rf_we",        32'(rf_we),       32'(exp_we));
    check("rf_waddr",     32'(rf_waddr),    32'(exp_a));
    check("rf_wdata",     rf_wdata,         exp_d);
    check("async_ready",  32'(async_ready), 32'(exp_ready));
    check("stall_req",    32'(stall_req),   32'(exp_stall));
    check("pending_mask", pending_mask,     exp_m);
    popped = !wact && (q.size() > 0);
    if (q.size() == 0 || popped) age_m = 0;
    else if (age_m < STARVE_MAX) age_m++;
    if (popped) void'(q.pop_front());
    if (av && exp_ready && aa != 5'd0) q.push_back({aa, ad});
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    wb_we = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'd0;
    async_valid = 1'b0; async_waddr = 5'd0; async_wdata = 32'd0;
    @(negedge clk); @(negedge clk);
    #1;
    check("por_rf_we", 32'(rf_we), 32'd0);
    check("por_ready", 32'(async_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("por_release_ready", 32'(async_ready), 32'd1);

    // T1: reset while two entries are held behind WB writes
    cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd20, 32'hA0);
    cycle(1'b1, 5'd3, 32'h22, 1'b1, 5'd21, 32'hA1);
    @(negedge clk);
    rst = 1'b1; wb_we = 1'b1; wb_waddr = 5'd9; async_valid = 1'b0;
    #1;
    check("t1_rf_we",   32'(rf_we),       32'd0);
    check("t1_ready",   32'(async_ready), 32'd0);
    check("t1_mask",    pending_mask,     32'd0);
    check("t1_stall",   32'(stall_req),   32'd0);
    q.delete(); age_m = 0;
    @(negedge clk);
    rst = 1'b0; wb_we = 1'b0; wb_waddr = 5'd0;
    #1;
    check("t1_rel_ready", 32'(async_ready), 32'd1);
    check("t1_rel_rf_we", 32'(rf_we),       32'd0);

    // T2: WB-only write passes straight through
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    check("t2_data", rf_wdata, 32'hDEADBEEF);

    // T3: async result drains in a WB gap on the following cycle
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
    check("t3_no_bypass", 32'(rf_we), 32'd0);
    idle();
    check("t3_addr", 32'(rf_waddr), 32'd7);
    check("t3_mask", pending_mask, 32'h80);
    idle();
    check("t3_mask_after", pending_mask, 32'd0);

    // T4: fill and starve behind continuous WB writes, then drain
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hB0);
    cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'hB1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    check("t4_full_ready", 32'(async_ready), 32'd0);
    check("t4_stall", 32'(stall_req), 32'd1);
    idle();
    check("t4_drain_addr", 32'(rf_waddr), 32'd8);
    idle();
    check("t4_stall_clear", 32'(stall_req), 32'd0);

    // T5: push and pop in the same cycle keeps occupancy at one
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hC0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hC1);
    check("t5_head", 32'(rf_waddr), 32'd10);
    idle();
    check("t5_next", 32'(rf_waddr), 32'd11);
    check("t5_ready", 32'(async_ready), 32'd1);
    idle();

    // T6: WB to $0 frees the slot; async to $0 is swallowed
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hD0);
    cycle(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0);
    check("t6_wb0_drain", 32'(rf_waddr), 32'd12);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hD1);
    idle();
    check("t6_a0_no_write", 32'(rf_we), 32'd0);
    check("t6_a0_mask", pending_mask, 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] wa, aa;
      wa = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      aa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cycle(1'($urandom_range(0, 99) < 60), wa, $urandom,
            1'($urandom_range(0, 1)), aa, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
